// File: rtl/a_prio_thresh_selector_if.sv
// ============================================================================
// Module      : a_prio_thresh_selector_if
// Description : Arbitration bus between the bus controller and the
//               fixed-priority threshold selector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface a_prio_thresh_selector_if #(
  parameter int NO_MASTERS = 2,
  parameter int NO_SLAVES  = 3,
  parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
  parameter int M_ID_WIDTH = $clog2(NO_MASTERS)
);
  logic                  state;
  logic [M_ID_WIDTH-1:0] master_in;
  logic [S_ID_WIDTH-1:0] slave_in;
  logic [S_ID_WIDTH-1:0] slave_id [0:NO_MASTERS-1];
  logic                  thresh;
  logic [M_ID_WIDTH-1:0] master_out;
  logic [S_ID_WIDTH-1:0] slave_out;
  logic                  request;

  modport master (
    output state, master_in, slave_in, slave_id,
    input  thresh, master_out, slave_out, request
  );

  modport slave (
    input  state, master_in, slave_in, slave_id,
    output thresh, master_out, slave_out, request
  );
endinterface

`default_nettype wire

// File: rtl/a_prio_thresh_selector.sv
// ============================================================================
// Module      : a_prio_thresh_selector
// Description : Fixed-priority master selector with a bus-hold threshold
//               counter. Define A_PRIO_THRESH_PREEMPT_EN to let any other
//               requester preempt once the holder has reached the threshold.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module a_prio_thresh_selector #(
  parameter int NO_MASTERS = 2,
  parameter int NO_SLAVES  = 3,
  parameter int THRESH     = 1000,
  parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
  parameter int M_ID_WIDTH = $clog2(NO_MASTERS)
) (
  input  wire logic              clk,
  input  wire logic              rst,
  a_prio_thresh_selector_if.slave bus
);

  localparam int                    c_cnt_w     = $clog2(THRESH + 1);
  localparam logic [c_cnt_w-1:0]    c_thresh    = c_cnt_w'(THRESH);
  localparam logic [S_ID_WIDTH-1:0] c_max_slave = S_ID_WIDTH'(NO_SLAVES);

  logic [c_cnt_w-1:0]    r_cnt;
  logic [M_ID_WIDTH-1:0] r_prev_master;
  logic                  r_thresh;

  logic [c_cnt_w-1:0]    w_cnt_next;
  logic                  w_preempt;
  logic [NO_MASTERS-1:0] w_eligible;
  logic                  w_request;
  logic [M_ID_WIDTH-1:0] w_master_sel;
  logic [S_ID_WIDTH-1:0] w_slave_sel;

`ifdef A_PRIO_THRESH_PREEMPT_EN
  assign w_preempt = r_thresh;
`else
  assign w_preempt = 1'b0;
`endif

  // In STOP only strictly higher-priority masters may take over, unless the
  // holder has exceeded its hold budget and preemption is enabled.
  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < NO_MASTERS; i++) begin
      w_eligible[i] = (bus.slave_id[i] != '0) && (bus.slave_id[i] <= c_max_slave) &&
                      (!bus.state ||
                       (M_ID_WIDTH'(i) < bus.master_in) ||
                       (w_preempt && (M_ID_WIDTH'(i) != bus.master_in)));
    end
  end

  // Scan from lowest priority upward so the lowest eligible index wins.
  always_comb begin
    w_request    = 1'b0;
    w_master_sel = bus.master_in;
    w_slave_sel  = bus.slave_in;
    for (int i = NO_MASTERS - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_request    = 1'b1;
        w_master_sel = M_ID_WIDTH'(i);
        w_slave_sel  = bus.slave_id[i];
      end
    end
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (!bus.state || (bus.master_in != r_prev_master)) begin
      w_cnt_next = '0;
    end else if (r_cnt != c_thresh) begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_prev_master <= '0;
      r_thresh      <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_next;
      r_prev_master <= bus.master_in;
      r_thresh      <= (w_cnt_next == c_thresh);
    end
  end

  assign bus.thresh     = r_thresh;
  assign bus.request    = w_request;
  assign bus.master_out = w_master_sel;
  assign bus.slave_out  = w_slave_sel;

endmodule

`default_nettype wire

// File: tb/tb_a_prio_thresh_selector.sv
// ============================================================================
// Module      : tb_a_prio_thresh_selector
// Description : Directed self-checking bench; 3 masters, 4 slaves, THRESH=4.
//               Expectations follow A_PRIO_THRESH_PREEMPT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_a_prio_thresh_selector;

  localparam int NO_MASTERS = 3;
  localparam int NO_SLAVES  = 4;
  localparam int THRESH     = 4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  a_prio_thresh_selector_if #(.NO_MASTERS(NO_MASTERS), .NO_SLAVES(NO_SLAVES)) bus ();

  a_prio_thresh_selector #(
    .NO_MASTERS(NO_MASTERS),
    .NO_SLAVES (NO_SLAVES),
    .THRESH    (THRESH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_sel(input string tag, input logic req, input logic [31:0] mo,
                           input logic [31:0] so);
    check({tag, "_req"}, 32'(bus.request), 32'(req));
    check({tag, "_mo"},  32'(bus.master_out), mo);
    check({tag, "_so"},  32'(bus.slave_out), so);
  endtask

  task automatic set_ids(input int a, input int b, input int c);
    bus.slave_id[0] = 3'(a);
    bus.slave_id[1] = 3'(b);
    bus.slave_id[2] = 3'(c);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.state = 1'b0;
    bus.master_in = '0;
    bus.slave_in = '0;
    set_ids(0, 0, 0);

    repeat (2) @(posedge clk);
    #1 check("reset_thresh", 32'(bus.thresh), 0);

    // NRML selection, idle echo and out-of-range ids
    @(negedge clk); rst = 1'b0; set_ids(2, 3, 0);
    #1 check_sel("nrml_23", 1'b1, 0, 2);
    @(negedge clk); bus.master_in = 2; bus.slave_in = 3; set_ids(0, 0, 0);
    #1 check_sel("nrml_idle", 1'b0, 2, 3);
    @(negedge clk); bus.master_in = 0; bus.slave_in = 1; set_ids(0, 0, 3);
    #1 check_sel("nrml_m2", 1'b1, 2, 3);
    @(negedge clk); bus.master_in = 1; bus.slave_in = 2; set_ids(5, 0, 0);
    #1 check_sel("nrml_oor", 1'b0, 1, 2);
    @(negedge clk); set_ids(7, 0, 4);
    #1 check_sel("nrml_oor_m2", 1'b1, 2, 4);

    // STOP with thresh=0
    @(negedge clk); bus.state = 1'b1; bus.master_in = 1; bus.slave_in = 3; set_ids(1, 3, 0);
    #1 check_sel("stop_m1", 1'b1, 0, 1);
    @(negedge clk); bus.master_in = 2; bus.slave_in = 4; set_ids(0, 2, 4);
    #1 check_sel("stop_m2", 1'b1, 1, 2);
    @(negedge clk); bus.master_in = 0; bus.slave_in = 2; set_ids(2, 1, 0);
    #1 check_sel("stop_m0", 1'b0, 0, 2);

    // Hold counter reaches THRESH after four stable STOP edges
    @(negedge clk); bus.state = 1'b0;
    @(negedge clk); bus.state = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1 check($sformatf("count_edge%0d", k), 32'(bus.thresh), (k == 4) ? 1 : 0);
    end
    @(posedge clk);
    #1 check("thresh_hold", 32'(bus.thresh), 1);
`ifdef A_PRIO_THRESH_PREEMPT_EN
    check_sel("stop_thr_m0", 1'b1, 1, 1);
`else
    check_sel("stop_thr_m0", 1'b0, 0, 2);
`endif
    @(negedge clk); bus.master_in = 1; bus.slave_in = 1;
    #1 check_sel("stop_thr_m1", 1'b1, 0, 2);
    @(posedge clk);
    #1 check("master_change", 32'(bus.thresh), 0);

    // Reset while the count sits at 3
    @(negedge clk); bus.state = 1'b0; bus.master_in = 0;
    @(negedge clk); bus.state = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("pre_reset", 32'(bus.thresh), 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    #1 check("mid_reset", 32'(bus.thresh), 0);
    @(negedge clk); rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1 check($sformatf("recount_edge%0d", k), 32'(bus.thresh), (k == 4) ? 1 : 0);
    end

    // Clear coinciding with saturation
    @(negedge clk); bus.state = 1'b0;
    @(negedge clk); bus.state = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); bus.state = 1'b0;
    @(posedge clk);
    #1 check("clear_wins", 32'(bus.thresh), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
